alu_mdu: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes all base integer ops with one cycle of latency.
- Adds RV32M multiply/divide/remainder through an iterative datapath: one bit per cycle, DATA_WIDTH cycles.
- Sits in the EX stage. The hazard unit stalls the pipeline while in_ready or out_valid is low.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_base.sv | 37 +++
 rtl/alu_mdu.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the handshaked ALU with iterative multiply/divide.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_AND    = 5'b00000,
      OP_XOR    = 5'b00001,
      OP_SUB    = 5'b00010,
      OP_OR     = 5'b00011,
      OP_ADD    = 5'b00100,
      OP_SRA    = 5'b00111,
      OP_EQ     = 5'b01000,
      OP_SLL    = 5'b01001,
      OP_LUI    = 5'b01010,
      OP_SRL    = 5'b01100,
      OP_SLT    = 5'b01110,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHSU = 5'b10010,
      OP_MULHU  = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Opcode bit positions; the divide family also uses bit 0 as "unsigned" and bit 1 as "remainder".
   localparam int M_GROUP_BIT    = 4;
   localparam int M_DIV_BIT      = 2;
   localparam int M_REM_BIT      = 1;
   localparam int M_UNSIGNED_BIT = 0;

   // Fill bits replicated across the word for the two divide corner cases.
   localparam logic DIV_ZERO_QUOT_FILL = 1'b1;
   localparam logic DIV_OVF_REM_FILL   = 1'b0;

endpackage

// File: rtl/alu_base.sv
// Purely combinational evaluator for the single-cycle base operations.
module alu_base
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  op_e                   i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   logic [SHAMT_W-1:0] w_shamt;

   assign w_shamt = i_b[SHAMT_W-1:0];

   always_comb begin
      o_result = '0;
      case (i_op)
         OP_AND:  o_result = i_a & i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_ADD:  o_result = i_a + i_b;
         OP_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
         OP_EQ:   o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a == i_b)};
         OP_SLL:  o_result = i_a << w_shamt;
         OP_LUI:  o_result = i_b;
         OP_SRL:  o_result = i_a >> w_shamt;
         OP_SLT:  o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked EX-stage ALU: base ops in one cycle, RV32M multiply/divide one bit per cycle.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5,
   parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult
);

   localparam int W  = DATA_WIDTH;
   localparam int W2 = 2 * DATA_WIDTH;
   localparam logic [SHAMT_W:0] COUNT_INIT = (SHAMT_W+1)'(DATA_WIDTH);
   localparam logic [SHAMT_W:0] COUNT_LAST = (SHAMT_W+1)'(1);
   localparam logic [W-1:0]     MOST_NEG   = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]     QUOT_ZERO  = {W{DIV_ZERO_QUOT_FILL}};
   localparam logic [W-1:0]     REM_OVF    = {W{DIV_OVF_REM_FILL}};

   state_e            r_state;
   logic              r_inReady;
   logic              r_outValid;
   logic [W-1:0]      r_result;
   logic [SHAMT_W:0]  r_count;
   logic [W2-1:0]     r_acc;
   logic [W2-1:0]     r_mcand;
   logic [W-1:0]      r_mplier;
   logic [W-1:0]      r_rem;
   logic [W-1:0]      r_quot;
   logic [W-1:0]      r_divisor;
   logic [1:0]        r_opLow;
   logic              r_negate;
   logic              r_negRem;

   logic              w_isMulOp;
   logic              w_isDivOp;
   logic              w_signA;
   logic              w_signB;
   logic              w_negA;
   logic              w_negB;
   logic [W-1:0]      w_magA;
   logic [W-1:0]      w_magB;
   logic              w_divZero;
   logic              w_divOvf;
   logic [W-1:0]      w_cornerResult;
   logic [W-1:0]      w_baseResult;
   op_e               w_iterOp;
   logic [W2-1:0]     w_iterA;
   logic [W2-1:0]     w_iterB;
   logic [W2-1:0]     w_iterSum;
   logic [W:0]        w_divShift;
   logic              w_borrow;
   logic [W-1:0]      w_remNext;
   logic [W-1:0]      w_quotNext;
   logic [W2-1:0]     w_mulProduct;
   logic [W-1:0]      w_mulResult;
   logic [W-1:0]      w_divResult;

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign ALUResult = r_result;

   // Opcode decode: bit 3 set inside the M group is an undefined code and falls back to base timing.
   assign w_isMulOp = Operation[M_GROUP_BIT] & ~Operation[3] & ~Operation[M_DIV_BIT];
   assign w_isDivOp = Operation[M_GROUP_BIT] & ~Operation[3] &  Operation[M_DIV_BIT];

   // MULH is signed x signed, MULHSU signed x unsigned, MUL/MULHU unsigned; DIV/REM signed when bit 0 is clear.
   assign w_signA = w_isMulOp ? (Operation[1] ^ Operation[0]) : ~Operation[M_UNSIGNED_BIT];
   assign w_signB = w_isMulOp ? (Operation[1:0] == 2'b01)     : ~Operation[M_UNSIGNED_BIT];
   assign w_negA  = w_signA & SrcA[W-1];
   assign w_negB  = w_signB & SrcB[W-1];
   assign w_magA  = w_negA ? -SrcA : SrcA;
   assign w_magB  = w_negB ? -SrcB : SrcB;

   assign w_divZero = (SrcB == '0);
   assign w_divOvf  = ~Operation[M_UNSIGNED_BIT] & (SrcA == MOST_NEG) & (SrcB == '1);
   assign w_cornerResult = w_divZero ? (Operation[M_REM_BIT] ? SrcA : QUOT_ZERO)
                                     : (Operation[M_REM_BIT] ? REM_OVF : SrcA);

   alu_base #(.DATA_WIDTH(W)) u_baseAlu (
      .i_op     (op_e'(Operation)),
      .i_a      (SrcA),
      .i_b      (SrcB),
      .o_result (w_baseResult)
   );

   // One double-width adder serves both iterations: accumulate in MUL, trial subtract in DIV.
   assign w_divShift = {r_rem, r_quot[W-1]};
   assign w_iterOp   = (r_state == DIV) ? OP_SUB : OP_ADD;
   assign w_iterA    = (r_state == DIV) ? {{(W-1){1'b0}}, w_divShift} : r_acc;
   assign w_iterB    = (r_state == DIV) ? {{W{1'b0}}, r_divisor}
                                        : (r_mplier[0] ? r_mcand : '0);

   alu_base #(.DATA_WIDTH(W2)) u_iterAlu (
      .i_op     (w_iterOp),
      .i_a      (w_iterA),
      .i_b      (w_iterB),
      .o_result (w_iterSum)
   );

   assign w_borrow   = |w_iterSum[W2-1:W];
   assign w_remNext  = w_borrow ? w_divShift[W-1:0] : w_iterSum[W-1:0];
   assign w_quotNext = {r_quot[W-2:0], ~w_borrow};

   assign w_mulProduct = r_negate ? -w_iterSum : w_iterSum;
   assign w_mulResult  = (r_opLow != 2'b00) ? w_mulProduct[W2-1:W] : w_mulProduct[W-1:0];
   assign w_divResult  = r_opLow[1] ? (r_negRem ? -w_remNext  : w_remNext)
                                    : (r_negate ? -w_quotNext : w_quotNext);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_result   <= '0;
         r_count    <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_divisor  <= '0;
         r_opLow    <= '0;
         r_negate   <= 1'b0;
         r_negRem   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_inReady <= 1'b0;
                  r_opLow   <= Operation[1:0];
                  r_negate  <= w_negA ^ w_negB;
                  r_negRem  <= w_negA;
                  if (w_isMulOp) begin
                     r_acc    <= '0;
                     r_mcand  <= {{W{1'b0}}, w_magA};
                     r_mplier <= w_magB;
                     r_count  <= COUNT_INIT;
                     r_state  <= MUL;
                  end else if (w_isDivOp && (w_divZero || w_divOvf)) begin
                     r_result   <= w_cornerResult;
                     r_outValid <= 1'b1;
                     r_state    <= DONE;
                  end else if (w_isDivOp) begin
                     r_rem     <= '0;
                     r_quot    <= w_magA;
                     r_divisor <= w_magB;
                     r_count   <= COUNT_INIT;
                     r_state   <= DIV;
                  end else begin
                     r_result   <= w_baseResult;
                     r_outValid <= 1'b1;
                     r_state    <= DONE;
                  end
               end
            end
            MUL: begin
               r_acc    <= w_iterSum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count - 1'b1;
               if (r_count == COUNT_LAST) begin
                  r_result   <= w_mulResult;
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DIV: begin
               r_rem   <= w_remNext;
               r_quot  <= w_quotNext;
               r_count <= r_count - 1'b1;
               if (r_count == COUNT_LAST) begin
                  r_result   <= w_divResult;
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
